dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter MEM_NBYTE, default 1024, meaning byte capacity of the data store.
REQ-002 SHALL have parameter WAIT_CYC, default 2, meaning access wait states (0..15).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  responder accepts a request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port req_load_sel  input  3  load type: LB=000, LH=001, LW=010, LBU=100, LHU=101.
REQ-011 SHALL have port req_store_sel  input  2  store type: SB=00, SH=01, SW=10.
REQ-012 SHALL have port rsp_valid  output  1  response available.
REQ-013 SHALL have port rsp_ready  input  1  initiator accepts the response.
REQ-014 SHALL have port rsp_rdata  output  32  load result, sign- or zero-extended.
REQ-015 SHALL have port rsp_err  output  1  request faulted.

Function
REQ-016 SHALL implement a three-state FSM: IDLE, WAIT, RESP.
REQ-017 SHALL drive req_ready=1 only in IDLE; a handshake is req_valid & req_ready.
REQ-018 SHALL, on handshake, register all req_* fields and load the wait counter with WAIT_CYC; the next state is WAIT, or RESP directly if WAIT_CYC=0.
REQ-019 SHALL, in WAIT, decrement the counter each cycle and perform the access on the cycle the counter reaches 0, then enter RESP.
REQ-020 SHALL assert rsp_valid exactly 1+WAIT_CYC cycles after the handshake cycle.
REQ-021 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready=1, then return to IDLE.
REQ-022 SHALL NOT accept a new request in the RESP cycle in which rsp_ready is seen; back-to-back throughput is one request per 2+WAIT_CYC cycles.
REQ-023 SHALL use little-endian byte order; loads extend per load_sel; stores write only the addressed 1/2/4 bytes.
REQ-024 SHALL flag rsp_err=1 for: addr+size > MEM_NBYTE; halfword with addr[0]=1; word with addr[1:0]!=0; load_sel in {011,110,111}; store_sel=11.
REQ-025 SHALL, on error, modify no memory byte and return rsp_rdata=0.
REQ-026 SHALL return rsp_rdata=0 for every store response.
REQ-027 SHALL drive rsp_rdata=0 and rsp_err=0 whenever rsp_valid=0.
REQ-028 SHALL ignore req_* inputs outside IDLE; changes there have no effect.

Reset
REQ-029 SHALL, while rst_n=0, force state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0 and req_ready=0; req_ready rises the first cycle after release.
REQ-030 SHALL leave memory contents unaffected by reset.
REQ-031 SHALL discard, without committing, a store still in WAIT when reset asserts; a store whose commit edge has passed remains written.

Structure
REQ-032 SHALL take the load_sel/store_sel encodings, the FSM state type and the access-size constants from the shared package riscv_mem_pkg, which the control logic also uses.
REQ-033 SHALL place byte-lane extract/extend and store-merge in one combinational sub-module, dmem_lane_fmt; the FSM, counter and storage stay in dmem_responder.

Verification
REQ-034 SHALL be covered by: WAIT_CYC=2, SW addr 0x10 data 0x8899AABB, then LW 0x10 -> rdata 0x8899AABB, rsp_valid 3 cycles after each handshake.
REQ-035 SHALL be covered by: after REQ-034, LB 0x13 -> 0xFFFFFF88; LBU 0x13 -> 0x00000088; LH 0x12 -> 0xFFFF8899; LHU 0x10 -> 0x0000AABB.
REQ-036 SHALL be covered by: SH addr 0x11 -> rsp_err=1, then LW 0x10 still 0x8899AABB; LW addr 0x3FE (MEM_NBYTE=1024) -> rsp_err=1, rdata 0.
REQ-037 SHALL be covered by: rsp_ready held 0 for 5 cycles in RESP -> outputs stable and req_ready=0 throughout; a new request with req_valid=1 during that time is not accepted.
REQ-038 SHALL be covered by: SB 0x20 data 0x5A with rst_n pulsed low during WAIT -> all outputs reset; a later LBU 0x20 does not return 0x5A.
REQ-039 SHALL be covered by: WAIT_CYC=0 -> rsp_valid exactly 1 cycle after the handshake; an illegal load_sel 011 -> rsp_err=1.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// ============================================================================
// Module : riscv_mem_pkg
// Brief  : Shared load/store encodings, responder FSM state type and access
//          size constants for the data-memory responder.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_mem_pkg;

  typedef enum logic [2:0] {
    LD_LB  = 3'b000,
    LD_LH  = 3'b001,
    LD_LW  = 3'b010,
    LD_LBU = 3'b100,
    LD_LHU = 3'b101
  } load_sel_e;

  typedef enum logic [1:0] {
    ST_SB = 2'b00,
    ST_SH = 2'b01,
    ST_SW = 2'b10
  } store_sel_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic [2:0] c_SIZE_NONE = 3'd0;
  localparam logic [2:0] c_SIZE_B    = 3'd1;
  localparam logic [2:0] c_SIZE_H    = 3'd2;
  localparam logic [2:0] c_SIZE_W    = 3'd4;

  // Byte count of an access; c_SIZE_NONE marks an illegal encoding.
  function automatic logic [2:0] access_size(input logic       we,
                                             input logic [2:0] load_sel,
                                             input logic [1:0] store_sel);
    access_size = c_SIZE_NONE;
    if (we) begin
      case (store_sel)
        ST_SB:   access_size = c_SIZE_B;
        ST_SH:   access_size = c_SIZE_H;
        ST_SW:   access_size = c_SIZE_W;
        default: access_size = c_SIZE_NONE;
      endcase
    end else begin
      case (load_sel)
        LD_LB, LD_LBU: access_size = c_SIZE_B;
        LD_LH, LD_LHU: access_size = c_SIZE_H;
        LD_LW:         access_size = c_SIZE_W;
        default:       access_size = c_SIZE_NONE;
      endcase
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_lane_fmt.sv
// ============================================================================
// Module : dmem_lane_fmt
// Brief  : Little-endian byte-lane load extract/extend and store merge.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_lane_fmt
  import riscv_mem_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  load_sel_i,
  input  logic [1:0]  store_sel_i,
  input  logic [31:0] rd_word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] ld_data_o,
  output logic [31:0] st_word_o,
  output logic [3:0]  st_be_o
);

  logic [31:0] w_shifted;

  always_comb begin
    w_shifted = rd_word_i >> {addr_lo_i, 3'b000};
    ld_data_o = '0;
    case (load_sel_i)
      LD_LB:   ld_data_o = {{24{w_shifted[7]}}, w_shifted[7:0]};
      LD_LH:   ld_data_o = {{16{w_shifted[15]}}, w_shifted[15:0]};
      LD_LW:   ld_data_o = w_shifted;
      LD_LBU:  ld_data_o = {24'd0, w_shifted[7:0]};
      LD_LHU:  ld_data_o = {16'd0, w_shifted[15:0]};
      default: ld_data_o = '0;
    endcase
  end

  // Replicate the right-aligned data across lanes; the enable picks the lane.
  always_comb begin
    st_word_o = '0;
    st_be_o   = '0;
    case (store_sel_i)
      ST_SB: begin
        st_word_o = {4{wdata_i[7:0]}};
        st_be_o   = 4'b0001 << addr_lo_i;
      end
      ST_SH: begin
        st_word_o = {2{wdata_i[15:0]}};
        st_be_o   = 4'b0011 << addr_lo_i;
      end
      ST_SW: begin
        st_word_o = wdata_i;
        st_be_o   = 4'b1111;
      end
      default: begin
        st_word_o = '0;
        st_be_o   = '0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// Module : dmem_responder
// Brief  : Wait-stated byte-addressable data memory with valid/ready request
//          and response channels and access fault detection.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder
  import riscv_mem_pkg::*;
#(
  parameter int MEM_NBYTE = 1024,
  parameter int WAIT_CYC  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_load_sel,
  input  logic [1:0]  req_store_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         c_AW    = $clog2(MEM_NBYTE);
  localparam int         c_NWORD = MEM_NBYTE / 4;
  localparam logic [3:0] c_WAIT  = 4'(WAIT_CYC);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  lsel_q;
  logic [1:0]  ssel_q;

  logic [31:0] mem_q [c_NWORD];

  logic              w_hs;
  logic              w_access;
  logic              w_a_we;
  logic [31:0]       w_a_addr;
  logic [31:0]       w_a_wdata;
  logic [2:0]        w_a_lsel;
  logic [1:0]        w_a_ssel;
  logic [2:0]        w_size;
  logic [32:0]       w_end;
  logic              w_err;
  logic [c_AW-3:0]   w_widx;
  logic [31:0]       w_rd_word;
  logic [31:0]       w_ld_data;
  logic [31:0]       w_st_word;
  logic [3:0]        w_st_be;

  assign w_hs = req_valid & ready_q;

  // With zero wait states the access happens on the handshake edge itself,
  // so the operands come straight from the request inputs.
  assign w_a_we    = (state_q == S_IDLE) ? req_we        : we_q;
  assign w_a_addr  = (state_q == S_IDLE) ? req_addr      : addr_q;
  assign w_a_wdata = (state_q == S_IDLE) ? req_wdata     : wdata_q;
  assign w_a_lsel  = (state_q == S_IDLE) ? req_load_sel  : lsel_q;
  assign w_a_ssel  = (state_q == S_IDLE) ? req_store_sel : ssel_q;

  assign w_access = ((state_q == S_IDLE) && w_hs && (c_WAIT == 4'd0)) ||
                    ((state_q == S_WAIT) && (cnt_q == 4'd1));

  assign w_size = access_size(w_a_we, w_a_lsel, w_a_ssel);
  assign w_end  = {1'b0, w_a_addr} + {30'd0, w_size};
  assign w_err  = (w_size == c_SIZE_NONE) ||
                  (w_end > 33'(MEM_NBYTE)) ||
                  ((w_size == c_SIZE_H) && w_a_addr[0]) ||
                  ((w_size == c_SIZE_W) && (w_a_addr[1:0] != 2'b00));

  assign w_widx    = w_a_addr[c_AW-1:2];
  assign w_rd_word = mem_q[w_widx];

  dmem_lane_fmt u_lane_fmt (
    .addr_lo_i   (w_a_addr[1:0]),
    .load_sel_i  (w_a_lsel),
    .store_sel_i (w_a_ssel),
    .rd_word_i   (w_rd_word),
    .wdata_i     (w_a_wdata),
    .ld_data_o   (w_ld_data),
    .st_word_o   (w_st_word),
    .st_be_o     (w_st_be)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (w_hs) begin
          cnt_d = c_WAIT;
          if (c_WAIT == 4'd0) state_d = S_RESP;
          else                state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (w_access) begin
      err_d   = w_err;
      rdata_d = (w_err || w_a_we) ? 32'd0 : w_ld_data;
    end
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      lsel_q  <= '0;
      ssel_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (w_hs) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        lsel_q  <= req_load_sel;
        ssel_q  <= req_store_sel;
      end
    end
  end

  // Storage has no reset; an in-flight store dies with the FSM state.
  always_ff @(posedge clk) begin
    if (w_access && w_a_we && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_st_be[b]) mem_q[w_widx][8*b +: 8] <= w_st_word[8*b +: 8];
      end
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// Module : tb_dmem_responder
// Brief  : Scoreboard bench for dmem_responder at WAIT_CYC=2 and WAIT_CYC=0.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        hold;
  logic        mon_en;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_load_sel;
  logic [1:0]  req_store_sel;
  logic        rsp_ready;

  wire         rr2, rv2, re2, rr0, rv0, re0;
  wire  [31:0] rd2, rd0;
  wire         m_req_ready = sel ? rr0 : rr2;
  wire         m_rsp_valid = sel ? rv0 : rv2;
  wire  [31:0] m_rsp_rdata = sel ? rd0 : rd2;
  wire         m_rsp_err   = sel ? re0 : re2;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
    logic [31:0] due;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] mmem [2][1024];

  dmem_responder #(.MEM_NBYTE(1024), .WAIT_CYC(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid & ~sel), .req_ready(rr2), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_load_sel(req_load_sel), .req_store_sel(req_store_sel),
    .rsp_valid(rv2), .rsp_ready(rsp_ready | sel),
    .rsp_rdata(rd2), .rsp_err(re2)
  );

  dmem_responder #(.MEM_NBYTE(1024), .WAIT_CYC(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid & sel), .req_ready(rr0), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_load_sel(req_load_sel), .req_store_sel(req_store_sel),
    .rsp_valid(rv0), .rsp_ready(rsp_ready | ~sel),
    .rsp_rdata(rd0), .rsp_err(re0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Reference: byte array, little-endian, sizes and faults from the rules.
  function automatic void model(input int d, input logic we, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [2:0] ls,
                                input logic [1:0] ss, output logic [31:0] rd,
                                output logic er);
    int          size;
    int          a;
    logic [31:0] val;
    if (we) size = (ss == 2'd0) ? 1 : (ss == 2'd1) ? 2 : (ss == 2'd2) ? 4 : 0;
    else    size = (ls == 3'd0 || ls == 3'd4) ? 1 :
                   (ls == 3'd1 || ls == 3'd5) ? 2 : (ls == 3'd2) ? 4 : 0;
    er = (size == 0) || (longint'(addr) + longint'(size) > 64'd1024) ||
         (size == 2 && addr[0]) || (size == 4 && addr[1:0] != 2'b00);
    rd  = 32'd0;
    val = 32'd0;
    a   = int'(addr[9:0]);
    if (!er) begin
      if (we) begin
        for (int i = 0; i < size; i++) mmem[d][a+i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < size; i++) val[8*i +: 8] = mmem[d][a+i];
        if (!ls[2] && size < 4 && val[8*size-1]) val = val | (32'hFFFF_FFFF << (8*size));
        rd = val;
      end
    end
  endfunction

  // Called at a negedge; returns at the negedge after the handshake.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [2:0] ls, input logic [1:0] ss, input bit track,
                        input bit lit, input logic [31:0] lit_rd, input logic lit_err);
    int          n;
    exp_t        e;
    logic [31:0] rd;
    logic        er;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    req_load_sel = ls; req_store_sel = ss;
    n = 0;
    while (!m_req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!m_req_ready) begin
      checks++; errors++;
      $display("FAIL req_accept_timeout actual=0 required=1");
      req_valid = 1'b0;
      return;
    end
    if (track) begin
      model(int'(sel), we, addr, wd, ls, ss, rd, er);
      e.rd  = lit ? lit_rd  : rd;
      e.err = lit ? lit_err : er;
      e.due = 32'(cyc + 1 + (sel ? 0 : 2));
      sbq.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    req_load_sel = 3'($urandom); req_store_sel = 2'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((sbq.size() != 0 || !m_req_ready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual=%0d required=0", sbq.size());
    end
  endtask

  task automatic rand_reqs(input int cnt);
    logic [31:0] addr;
    int          r;
    for (int i = 0; i < cnt; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7)      addr = 32'($urandom_range(0, 63));
      else if (r < 9) addr = 32'h3F0 + 32'($urandom_range(0, 15));
      else            addr = $urandom;
      do_req(1'($urandom), addr, $urandom, 3'($urandom_range(0, 7)),
             2'($urandom_range(0, 3)), 1'b1, 1'b0, 32'd0, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  // Response channel back-pressure
  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      rsp_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops on the first cycle of each response, then holds it.
  initial begin
    bit   prev  = 1'b0;
    bit   bogus = 1'b0;
    exp_t cur   = '0;
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (m_rsp_valid) begin
        if (!prev) begin
          if (sbq.size() == 0) begin
            bogus = 1'b1;
            checks++; errors++;
            $display("FAIL unexpected_rsp actual=0x%08h required=none", m_rsp_rdata);
          end else begin
            bogus = 1'b0;
            cur   = sbq.pop_front();
            chk("rsp_latency", 32'(cyc), cur.due);
          end
        end
        if (!bogus) begin
          chk("rsp_rdata", m_rsp_rdata, cur.rd);
          chk("rsp_err", {31'd0, m_rsp_err}, {31'd0, cur.err});
        end
      end else begin
        chk("idle_rdata", m_rsp_rdata, 32'd0);
        chk("idle_err", {31'd0, m_rsp_err}, 32'd0);
      end
      prev = m_rsp_valid;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b1; sel = 1'b0; hold = 1'b0; mon_en = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_load_sel = '0; req_store_sel = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready2", {31'd0, rr2}, 32'd0);
    chk("rst_req_ready0", {31'd0, rr0}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rv2}, 32'd0);
    chk("rst_rsp_rdata", rd2, 32'd0);
    chk("rst_rsp_err", {31'd0, re2}, 32'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    #1 chk("ready_at_release", {31'd0, m_req_ready}, 32'd0);
    @(negedge clk);
    chk("ready_after_release", {31'd0, m_req_ready}, 32'd1);

    for (int d = 0; d < 2; d++) begin
      sel = 1'(d);
      for (int w = 0; w < 16; w++)
        do_req(1'b1, 32'(4*w), $urandom, 3'd0, 2'b10, 1'b1, 1'b0, 32'd0, 1'b0);
      for (int w = 0; w < 4; w++)
        do_req(1'b1, 32'h3F0 + 32'(4*w), $urandom, 3'd0, 2'b10, 1'b1, 1'b0, 32'd0, 1'b0);
      drain();
    end

    sel = 1'b0;
    do_req(1'b1, 32'h10, 32'h8899AABB, 3'd0,   2'b10, 1'b1, 1'b1, 32'h0, 1'b0);
    do_req(1'b0, 32'h10, 32'h0,        3'b010, 2'b00, 1'b1, 1'b1, 32'h8899AABB, 1'b0);
    do_req(1'b0, 32'h13, 32'h0,        3'b000, 2'b00, 1'b1, 1'b1, 32'hFFFFFF88, 1'b0);
    do_req(1'b0, 32'h13, 32'h0,        3'b100, 2'b00, 1'b1, 1'b1, 32'h00000088, 1'b0);
    do_req(1'b0, 32'h12, 32'h0,        3'b001, 2'b00, 1'b1, 1'b1, 32'hFFFF8899, 1'b0);
    do_req(1'b0, 32'h10, 32'h0,        3'b101, 2'b00, 1'b1, 1'b1, 32'h0000AABB, 1'b0);
    do_req(1'b1, 32'h11, 32'h1234,     3'd0,   2'b01, 1'b1, 1'b1, 32'h0, 1'b1);
    do_req(1'b0, 32'h10, 32'h0,        3'b010, 2'b00, 1'b1, 1'b1, 32'h8899AABB, 1'b0);
    do_req(1'b0, 32'h3FE, 32'h0,       3'b010, 2'b00, 1'b1, 1'b1, 32'h0, 1'b1);
    drain();

    // Stall in RESP while a competing request is offered.
    hold = 1'b1;
    do_req(1'b0, 32'h10, 32'h0, 3'b010, 2'b00, 1'b1, 1'b1, 32'h8899AABB, 1'b0);
    n = 0;
    while (!m_rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("stall_rsp_seen", {31'd0, m_rsp_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10;
      req_wdata = 32'hDEADBEEF; req_store_sel = 2'b10;
      chk("stall_req_ready", {31'd0, m_req_ready}, 32'd0);
      chk("stall_rsp_valid", {31'd0, m_rsp_valid}, 32'd1);
      @(negedge clk);
    end
    req_valid = 1'b0;
    hold = 1'b0;
    drain();
    do_req(1'b0, 32'h10, 32'h0, 3'b010, 2'b00, 1'b1, 1'b1, 32'h8899AABB, 1'b0);
    do_req(1'b1, 32'h20, 32'h11223344, 3'd0, 2'b10, 1'b1, 1'b1, 32'h0, 1'b0);
    drain();

    // Reset while a byte store is still waiting.
    do_req(1'b1, 32'h20, 32'h5A, 3'd0, 2'b00, 1'b0, 1'b0, 32'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("wrst_req_ready", {31'd0, m_req_ready}, 32'd0);
    chk("wrst_rsp_valid", {31'd0, m_rsp_valid}, 32'd0);
    chk("wrst_rsp_rdata", m_rsp_rdata, 32'd0);
    chk("wrst_rsp_err", {31'd0, m_rsp_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("wrst_ready_back", {31'd0, m_req_ready}, 32'd1);
    do_req(1'b0, 32'h20, 32'h0, 3'b100, 2'b00, 1'b1, 1'b1, 32'h00000044, 1'b0);
    drain();

    rand_reqs(200);
    drain();

    sel = 1'b1;
    do_req(1'b1, 32'h30, 32'hCAFEF00D, 3'd0,   2'b10, 1'b1, 1'b1, 32'h0, 1'b0);
    do_req(1'b0, 32'h30, 32'h0,        3'b010, 2'b00, 1'b1, 1'b1, 32'hCAFEF00D, 1'b0);
    do_req(1'b0, 32'h30, 32'h0,        3'b011, 2'b00, 1'b1, 1'b1, 32'h0, 1'b1);
    rand_reqs(150);
    drain();

    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
